// File: rtl/vga_frame_mon_if.sv
// Pixel-bus and result-record bundle shared by the video source/reader and
// the frame monitor. PW is the pixel width in bits (CH*BPC).
interface vga_frame_mon_if #(
    parameter int PW = 24
);
    // video side
    logic          pix_en;
    logic [PW-1:0] pixel_data;
    logic          line_active;
    logic          frame_end;
    // result side
    logic          synced;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_frame_idx;
    logic [15:0]   res_lines;
    logic [15:0]   res_bad_lines;
    logic [31:0]   res_checksum;
    logic          res_ok;
    logic          overflow;

    // master: video generator plus result reader
    modport master (
        output pix_en, pixel_data, line_active, frame_end, res_ready,
        input  synced, res_valid, res_frame_idx, res_lines, res_bad_lines,
               res_checksum, res_ok, overflow
    );

    // slave: the frame monitor
    modport slave (
        input  pix_en, pixel_data, line_active, frame_end, res_ready,
        output synced, res_valid, res_frame_idx, res_lines, res_bad_lines,
               res_checksum, res_ok, overflow
    );
endinterface

// File: rtl/vga_frame_mon.sv
// Video frame monitor: checks per-frame geometry against WIDTH x HEIGHT,
// folds every active pixel into a rotate/xor signature, and offers one
// result record per frame through a single-entry valid/ready register.
module vga_frame_mon #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CH     = 3,
    parameter int BPC    = 8
) (
    input  logic            clk,
    input  logic            rst,
    vga_frame_mon_if.slave  bus
);
    localparam int PCW = $clog2(WIDTH + 2);
    localparam logic [PCW-1:0] PIX_MAX = PCW'(WIDTH + 1);
    localparam logic [PCW-1:0] PIX_EXP = PCW'(WIDTH);
    localparam logic [15:0]    LINES_EXP = 16'(HEIGHT);

    generate
        if (CH * BPC > 32) begin : g_bad_pixel_width
            $error("vga_frame_mon: CH*BPC must not exceed 32");
        end
        if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_geometry
            $error("vga_frame_mon: WIDTH and HEIGHT must be at least 1");
        end
    endgenerate

    typedef enum logic {S_SYNC, S_RUN} state_t;

    state_t          r_state, w_state_next;
    logic            r_la, r_la_d, r_fe, r_fe_d;
    logic [PCW-1:0]  r_pix_cnt;
    logic [15:0]     r_line_cnt, r_bad_cnt, r_frame_idx;
    logic [31:0]     r_csum;
    logic            r_res_valid, r_res_ok, r_ovf;
    logic [15:0]     r_res_idx, r_res_lines, r_res_bad;
    logic [31:0]     r_res_csum;

    logic            w_la_fall, w_fe_rise, w_run, w_take, w_close, w_frame, w_sync_hit;
    logic [PCW-1:0]  w_pix_a, w_pix_b;
    logic [31:0]     w_csum_a, w_pix32;
    logic [15:0]     w_line_b, w_bad_b;
    logic            w_ok;

    // Frame-level control: SYNC waits for the first frame_end edge, RUN measures frames.
    always_comb begin
        w_state_next = r_state;
        w_sync_hit   = 1'b0;
        w_frame      = 1'b0;
        case (r_state)
            S_SYNC: if (w_fe_rise) begin
                w_state_next = S_RUN;
                w_sync_hit   = 1'b1;
            end
            S_RUN: w_frame = w_fe_rise;
            default: w_state_next = S_SYNC;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_SYNC;
        else     r_state <= w_state_next;
    end

    // Single input register on the framing signals plus previous-sample copies for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_la   <= 1'b0;
            r_la_d <= 1'b0;
            r_fe   <= 1'b0;
            r_fe_d <= 1'b0;
        end else begin
            r_la   <= bus.line_active;
            r_la_d <= r_la;
            r_fe   <= bus.frame_end;
            r_fe_d <= r_fe;
        end
    end

    assign w_la_fall = r_la_d & ~r_la;
    assign w_fe_rise = r_fe & ~r_fe_d;
    assign w_run     = (r_state == S_RUN);
    // Pixels use the raw strobe/line_active so data and qualifier share one edge.
    assign w_take    = w_run & bus.pix_en & bus.line_active;
    // A line still open when the frame ends is closed and counted with that frame.
    assign w_close   = w_run & (w_la_fall | (w_fe_rise & r_la));
    assign w_pix32   = 32'(bus.pixel_data);

    // Fold pixel, then line end, then frame end, so coincident events all land in this frame.
    always_comb begin
        w_pix_a  = r_pix_cnt;
        w_csum_a = r_csum;
        if (w_take) begin
            w_pix_a  = (r_pix_cnt == PIX_MAX) ? r_pix_cnt : r_pix_cnt + PCW'(1);
            w_csum_a = {r_csum[30:0], r_csum[31]} ^ w_pix32;
        end
        w_line_b = r_line_cnt;
        w_bad_b  = r_bad_cnt;
        w_pix_b  = w_pix_a;
        if (w_close) begin
            w_line_b = (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
            if (w_pix_a != PIX_EXP)
                w_bad_b = (r_bad_cnt == 16'hFFFF) ? r_bad_cnt : r_bad_cnt + 16'd1;
            w_pix_b = '0;
        end
        w_ok = (w_line_b == LINES_EXP) && (w_bad_b == 16'd0);
    end

    // Per-frame accumulators; cleared at every frame boundary and on synchronisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_csum      <= '0;
            r_frame_idx <= '0;
        end else if (w_sync_hit || w_frame) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_csum      <= '0;
            r_frame_idx <= w_sync_hit ? 16'd0 : r_frame_idx + 16'd1;
        end else begin
            r_pix_cnt   <= w_pix_b;
            r_line_cnt  <= w_line_b;
            r_bad_cnt   <= w_bad_b;
            r_csum      <= w_csum_a;
        end
    end

    // Single-entry result register: load when empty or being read, else drop and flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_lines <= '0;
            r_res_bad   <= '0;
            r_res_csum  <= '0;
            r_res_ok    <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_frame && (!r_res_valid || bus.res_ready)) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= r_frame_idx;
            r_res_lines <= w_line_b;
            r_res_bad   <= w_bad_b;
            r_res_csum  <= w_csum_a;
            r_res_ok    <= w_ok;
        end else if (w_frame) begin
            r_ovf       <= 1'b1;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.synced        = w_run;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_frame_idx = r_res_idx;
    assign bus.res_lines     = r_res_lines;
    assign bus.res_bad_lines = r_res_bad;
    assign bus.res_checksum  = r_res_csum;
    assign bus.res_ok        = r_res_ok;
    assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_vga_frame_mon.sv
// Randomised bench for vga_frame_mon with WIDTH=4, HEIGHT=2, 24-bit pixels.
// The reference model tracks frames as lists of line lengths and pixel values.
module tb_vga_frame_mon;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_frame_mon_if #(.PW(PW)) b ();

    vga_frame_mon #(.WIDTH(W), .HEIGHT(H), .CH(3), .BPC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_synced;
    bit          m_valid;
    bit          m_ovf;
    int          m_idx;
    int          m_lines, m_bad;
    logic [31:0] m_csum;
    int          r_lines, r_bad, r_idx;
    logic [31:0] r_csum;
    bit          r_ok;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".synced"},   32'(b.synced),        32'(m_synced));
        check_val({tag, ".valid"},    32'(b.res_valid),     32'(m_valid));
        check_val({tag, ".idx"},      32'(b.res_frame_idx), 32'(r_idx));
        check_val({tag, ".lines"},    32'(b.res_lines),     32'(r_lines));
        check_val({tag, ".bad"},      32'(b.res_bad_lines), 32'(r_bad));
        check_val({tag, ".checksum"}, b.res_checksum,       r_csum);
        check_val({tag, ".ok"},       32'(b.res_ok),        32'(r_ok));
        check_val({tag, ".overflow"}, 32'(b.overflow),      32'(m_ovf));
        $display("txn %s: valid=%0b idx=%0d lines=%0d bad=%0d csum=0x%08h ok=%0b ovf=%0b",
                 tag, b.res_valid, b.res_frame_idx, b.res_lines, b.res_bad_lines,
                 b.res_checksum, b.res_ok, b.overflow);
    endtask

    task automatic model_reset();
        m_synced = 0; m_valid = 0; m_ovf = 0; m_idx = 0;
        m_lines = 0; m_bad = 0; m_csum = '0;
        r_lines = 0; r_bad = 0; r_idx = 0; r_csum = '0; r_ok = 0;
    endtask

    // Idle cycles outside a line, with junk on pix_en/pixel_data that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b.line_active = 1'b0;
            b.pix_en      = 1'($urandom_range(0, 1));
            b.pixel_data  = PW'($urandom);
        end
    endtask

    // One line of n pixels. kind: 0 random, 1 all zero, 2 first pixel 1 then zero.
    task automatic send_line(input int n, input int kind);
        logic [PW-1:0] p;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                b.line_active = 1'b1;
                b.pix_en      = 1'b0;
                b.pixel_data  = PW'($urandom);
            end
            if (kind == 0)                p = PW'($urandom);
            else if (kind == 2 && i == 0) p = PW'(1);
            else                          p = '0;
            @(negedge clk);
            b.line_active = 1'b1;
            b.pix_en      = 1'b1;
            b.pixel_data  = p;
            m_csum = (m_csum << 1) | (m_csum >> 31);
            m_csum = m_csum ^ 32'(p);
        end
        @(negedge clk);
        b.line_active = 1'b1;
        b.pix_en      = 1'b0;
        m_lines++;
        if (n != W) m_bad++;
        idle(2);
    endtask

    // Frame end pulse; ready is offered exactly on the cycle the record would load.
    task automatic send_frame_end(input bit ready, input int hold);
        @(negedge clk);
        b.frame_end = 1'b1;
        b.res_ready = 1'b0;
        @(negedge clk);
        b.res_ready = ready;
        @(negedge clk);
        b.res_ready = 1'b0;
        for (int i = 0; i < hold; i++) @(negedge clk);
        b.frame_end = 1'b0;
        idle(3);
        if (!m_synced) begin
            m_synced = 1;
            m_idx    = 0;
        end else begin
            if (!m_valid || ready) begin
                m_valid = 1;
                r_lines = m_lines;
                r_bad   = m_bad;
                r_csum  = m_csum;
                r_idx   = m_idx;
                r_ok    = (m_lines == H) && (m_bad == 0);
            end else begin
                m_ovf = 1;
            end
            m_idx = (m_idx + 1) % 65536;
        end
        m_lines = 0; m_bad = 0; m_csum = '0;
    endtask

    task automatic accept();
        @(negedge clk);
        b.res_ready = 1'b1;
        @(negedge clk);
        b.res_ready = 1'b0;
        m_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        b.line_active = 1'b0; b.pix_en = 1'b0; b.frame_end = 1'b0; b.res_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("in_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_frame(input bit ready);
        int nl;
        nl = $urandom_range(1, 3);
        for (int l = 0; l < nl; l++) send_line($urandom_range(W - 1, W + 2), 0);
        send_frame_end(ready, $urandom_range(0, 3));
    endtask

    initial begin
        b.pix_en = 1'b0; b.pixel_data = '0; b.line_active = 1'b0;
        b.frame_end = 1'b0; b.res_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // lines before the first frame_end are ignored
        send_line(3, 0);
        send_line(4, 0);
        check_all("presync");
        send_frame_end(1'b0, 2);
        check_all("sync");

        // all-zero frame
        send_line(W, 1); send_line(W, 1);
        send_frame_end(1'b0, 0);
        check_all("zero_frame");
        accept();
        check_all("accept0");

        // single 1 in the first pixel rotates up by the remaining 7 pixels
        send_line(W, 2); send_line(W, 1);
        send_frame_end(1'b0, 1);
        check_all("one_pixel");
        check_val("one_pixel.const", b.res_checksum, 32'h0000_0080);
        accept();

        // wrong line lengths
        send_line(5, 0); send_line(3, 0);
        send_frame_end(1'b0, 0);
        check_all("bad_len");
        check_val("bad_len.const", 32'(b.res_bad_lines), 32'd2);
        accept();

        // random frames, each accepted
        for (int f = 0; f < 6; f++) begin
            random_frame(1'b0);
            check_all($sformatf("rand%0d", f));
            accept();
        end

        // reader stalls across two frames: first record held, overflow set
        random_frame(1'b0);
        check_all("stall_a");
        random_frame(1'b0);
        check_all("stall_b");
        accept();
        check_all("stall_accept");
        random_frame(1'b0);
        check_all("stall_next");

        // replace-on-read and mixed ready
        for (int f = 0; f < 6; f++) begin
            random_frame(1'($urandom_range(0, 1)));
            check_all($sformatf("mix%0d", f));
            if ($urandom_range(0, 1) == 1) accept();
        end

        // reset in the middle of line 2
        send_line(W, 0);
        @(negedge clk);
        b.line_active = 1'b1; b.pix_en = 1'b1; b.pixel_data = PW'($urandom);
        @(negedge clk);
        do_reset();
        check_all("after_reset");
        send_line(W, 0);
        send_frame_end(1'b1, 0);
        check_all("resync");
        send_line(W, 0); send_line(W, 0);
        send_frame_end(1'b0, 0);
        check_all("first_after_reset");
        check_val("first_after_reset.idx0", 32'(b.res_frame_idx), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
